// File: rtl/move_link_pkg.sv
// Shared definitions for the PMOD move link (move_tx, move_rx, user_io).
// MOVE_RX_PARITY_EN adds the PARITY receiver state.
package move_link_pkg;

  localparam int DEF_PKT_LEN       = 8;
  localparam int DEF_SAMP_PER_BIT  = 16;
  localparam int DEF_CLK_PER_SAMP  = 423;
  localparam int DEF_WAITING_COUNT = 65_000;

  // Move packet layout: row in the upper nibble, column in the lower nibble.
  localparam int MOVE_COL_LSB = 0;
  localparam int MOVE_COL_MSB = 3;
  localparam int MOVE_ROW_LSB = 4;
  localparam int MOVE_ROW_MSB = 7;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef MOVE_RX_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_HOLDOFF
  } rx_state_t;

endpackage

// File: rtl/samp_tick_gen.sv
// Sample-tick prescaler: a one-cycle tick every CLK_PER_SAMP clocks.
// restart realigns the phase so the first tick lands CLK_PER_SAMP+1 cycles later.
module samp_tick_gen
  import move_link_pkg::*;
#(
  parameter int CLK_PER_SAMP = DEF_CLK_PER_SAMP
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_PER_SAMP > 1) ? $clog2(CLK_PER_SAMP) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_PER_SAMP - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= RELOAD;
      tick <= 1'b0;
    end else if (cnt == '0) begin
      cnt  <= RELOAD;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt - 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/move_rx.sv
// Receiving end of the PMOD move link: oversampling 8N1 UART (8E1 with MOVE_RX_PARITY_EN).
//   state   | meaning
//   IDLE    | waiting for a start-bit falling edge
//   START   | waiting for the start-bit centre to reject glitches
//   DATA    | sampling payload bits, LSB first
//   PARITY  | sampling the even-parity bit (MOVE_RX_PARITY_EN only)
//   STOP    | sampling the stop bit, then publishing or flagging the frame
//   HOLDOFF | after a framing error, waiting for a long idle-high run
module move_rx
  import move_link_pkg::*;
#(
  parameter int PKT_LEN       = DEF_PKT_LEN,
  parameter int SAMP_PER_BIT  = DEF_SAMP_PER_BIT,
  parameter int CLK_PER_SAMP  = DEF_CLK_PER_SAMP,
  parameter int WAITING_COUNT = DEF_WAITING_COUNT
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rx,
  output logic               ready,
  output logic [PKT_LEN-1:0] data_out,
  output logic               frame_err,
  output logic               busy
);

  localparam int SW = $clog2(SAMP_PER_BIT);
  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int HW = $clog2(WAITING_COUNT);
  localparam logic [SW-1:0] HALF_RELOAD = SW'(SAMP_PER_BIT / 2 - 1);
  localparam logic [SW-1:0] BIT_RELOAD  = SW'(SAMP_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(PKT_LEN - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(WAITING_COUNT - 1);

  rx_state_t state, state_nxt;

  logic rx_meta, rx_s, rx_q;
  logic fall, tick, restart, samp_due, frame_ok;
  logic ready_set, err_set;
  logic [SW-1:0] samp_cnt;
  logic [BW-1:0] bit_idx;
  logic [HW-1:0] hold_cnt;
  logic [PKT_LEN-1:0] shreg;
`ifdef MOVE_RX_PARITY_EN
  logic par_bit;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  assign fall     = rx_q & ~rx_s;
  assign samp_due = tick && (samp_cnt == '0);

`ifdef MOVE_RX_PARITY_EN
  assign frame_ok = rx_s & ~(^{shreg, par_bit});
`else
  assign frame_ok = rx_s;
`endif

  samp_tick_gen #(
    .CLK_PER_SAMP(CLK_PER_SAMP)
  ) u_samp_tick_gen (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= RX_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    ready_set = 1'b0;
    err_set   = 1'b0;
    case (state)
      RX_IDLE: begin
        if (fall) begin
          restart   = 1'b1;
          state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (samp_due) state_nxt = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
`ifdef MOVE_RX_PARITY_EN
        if (samp_due && bit_idx == LAST_BIT) state_nxt = RX_PARITY;
`else
        if (samp_due && bit_idx == LAST_BIT) state_nxt = RX_STOP;
`endif
      end
`ifdef MOVE_RX_PARITY_EN
      RX_PARITY: begin
        if (samp_due) state_nxt = RX_STOP;
      end
`endif
      RX_STOP: begin
        if (samp_due) begin
          if (frame_ok) begin
            ready_set = 1'b1;
            state_nxt = RX_IDLE;
          end else begin
            err_set   = 1'b1;
            state_nxt = RX_HOLDOFF;
          end
        end
      end
      RX_HOLDOFF: begin
        if (rx_s && hold_cnt == HOLD_LAST) state_nxt = RX_IDLE;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      samp_cnt <= '0;
      bit_idx  <= '0;
      hold_cnt <= '0;
      shreg    <= '0;
`ifdef MOVE_RX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      if (state == RX_IDLE) begin
        if (fall) samp_cnt <= HALF_RELOAD;
      end else if (tick) begin
        samp_cnt <= (samp_cnt == '0) ? BIT_RELOAD : samp_cnt - 1'b1;
      end

      if (state == RX_START && samp_due) bit_idx <= '0;
      if (state == RX_DATA && samp_due) begin
        shreg[bit_idx] <= rx_s;
        if (bit_idx != LAST_BIT) bit_idx <= bit_idx + 1'b1;
      end
`ifdef MOVE_RX_PARITY_EN
      if (state == RX_PARITY && samp_due) par_bit <= rx_s;
`endif

      // Only an unbroken run of high samples counts toward resync.
      if (state != RX_HOLDOFF || !rx_s)  hold_cnt <= '0;
      else if (hold_cnt != HOLD_LAST)    hold_cnt <= hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ready     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      data_out  <= '0;
    end else begin
      ready     <= ready_set;
      frame_err <= err_set;
      busy      <= (state_nxt != RX_IDLE);
      if (ready_set) data_out <= shreg;
    end
  end

endmodule

// File: doc/move_rx.md
# move_rx

Serial receiver for 8-bit move packets exchanged between the two boards over the PMOD link. It is the receiving end of the 8N1 UART framing used by the move transmitter. It oversamples the incoming line, validates start and stop bits, and presents each completed move to the game FSM as a one-cycle `ready` strobe with a stable `data_out` bus. It sits between the PMOD input pin and the move mux in front of `game_fsm`.

## Interface
- `PKT_LEN`, 8: payload bits per packet, sent LSB first.
- `SAMP_PER_BIT`, 16: samples per bit period; must be even and at least 4.
- `CLK_PER_SAMP`, 423: clock cycles per sample tick (65 MHz / 9600 baud / 16).
- `WAITING_COUNT`, 65_000: consecutive idle-high cycles required to resynchronise after a framing error.
- `clk_in` input 1: system clock, 65 MHz.
- `rst_n_in` input 1: reset; asynchronous, active-low.
- `rx` input 1: serial line; idles high; asynchronous to `clk_in`.
- `ready` output 1: one-cycle pulse when a valid packet has been received.
- `data_out` output PKT_LEN: last valid payload; held until the next valid packet.
- `frame_err` output 1: one-cycle pulse on a stop-bit (or parity) failure.
- `busy` output 1: high from start-bit detection until the block returns to IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1.
- Falling-edge detect on the synchronised line uses one registered copy.
- States: IDLE, START, DATA, PARITY (macro only), STOP, HOLDOFF.
- IDLE:
  - On a falling edge, clear the prescaler and sample counter, then go to START.
  - Assert `busy` from the next cycle.
- START:
  - After SAMP_PER_BIT/2 ticks, check the line.
  - If the line is low, go to DATA with the bit index at 0.
  - If the line is high, this is a false start: return to IDLE and drop `busy`. No pulse is issued.
- DATA:
  - Every SAMP_PER_BIT ticks, shift the sampled bit into the shift register at the bit-index position (LSB first).
  - After bit PKT_LEN-1, go to STOP (or to PARITY).
- STOP: sample after SAMP_PER_BIT ticks.
  - If high (and parity is OK), load the shift register into `data_out`, pulse `ready`, and go to IDLE.
  - Otherwise pulse `frame_err`, leave `data_out` unchanged, and go to HOLDOFF.
- HOLDOFF:
  - Count consecutive synchronised-high cycles. Any low sample clears the count.
  - When the count reaches WAITING_COUNT, go to IDLE.
  - A falling edge during HOLDOFF is ignored.
- The shift register is internal only; partial packets are never visible on `data_out`.
- `ready` and `frame_err` are never high in the same cycle.

## Timing
- Reset values: `ready`=0, `frame_err`=0, `busy`=0, `data_out`=0, state=IDLE, all counters at 0.
- Reset mid-packet: all outputs return to reset values immediately (asynchronously). No pulse is issued after release.
- Sample tick: one cycle every CLK_PER_SAMP cycles. The prescaler restarts on start-bit detection, so sample points are deterministic.
- Sample points, in ticks after the start edge:
  - Start-bit centre: SAMP_PER_BIT/2.
  - Data bit i centre: SAMP_PER_BIT/2 + SAMP_PER_BIT·(i+1).
  - Stop-bit centre: SAMP_PER_BIT/2 + SAMP_PER_BIT·(PKT_LEN+1).
- Latency from the first clock edge that samples `rx` low to `ready` high is 3 + 152·CLK_PER_SAMP cycles with the defaults, and 3 + 168·CLK_PER_SAMP with parity.
- `data_out` updates in the same cycle that `ready` rises.
- Back-to-back packets: a start bit beginning immediately after the stop-bit sample is accepted. IDLE is re-entered one cycle after `ready`.
- Counter widths: $clog2 of each maximum. There is no wrap-around within a packet.

## Configuration
- Macro: `MOVE_RX_PARITY_EN`.
- Defined:
  - An even-parity bit follows the payload and is sampled in the PARITY state.
  - The parity check covers the payload plus the parity bit; an odd total counts as a failure.
  - A parity failure is reported exactly like a stop-bit failure (`frame_err` pulse, then HOLDOFF).
- Undefined: the PARITY state and its logic are absent, and the frame is 8N1.
- The transmitter must be built with the same macro setting.

## Structure
- Shared package `move_link_pkg` holds:
  - the `rx_state_t` enum;
  - default `PKT_LEN`, `SAMP_PER_BIT`, `CLK_PER_SAMP` and `WAITING_COUNT`;
  - the move packet field layout (row/column nibble positions), which is shared with the transmitter and `user_io`.
- One sub-module: `samp_tick_gen`. It is a prescaler with a synchronous `restart` input that produces the one-cycle sample tick.

## Test plan
- Send 0x35 as 8N1 with defaults:
  - `ready` pulses once, exactly 3 + 152·423 cycles after the start edge.
  - `data_out`=0x35; `frame_err` stays 0.
- A 100-cycle low glitch on idle `rx` is a false start: no `ready`, no `frame_err`, and `busy` falls back to 0 about SAMP_PER_BIT/2·423 cycles after the glitch.
- Send 0xA7, then 0x3C with its stop bit forced low:
  - `frame_err` pulses once and `data_out` stays 0xA7.
  - A packet 0x11 sent before WAITING_COUNT idle cycles have elapsed is ignored.
  - 0x11 sent after the holdoff yields `ready` with `data_out`=0x11.
- Back-to-back 0x00 then 0xFF with no idle gap: two `ready` pulses, with `data_out` 0x00 then 0xFF.
- Assert `rst_n_in` low during bit 4 of 0x5A: outputs go to 0 immediately. A clean 0x5A sent after release is received correctly.
- With `MOVE_RX_PARITY_EN`: 0x07 sent with parity bit 1 → `ready`, `data_out`=0x07. Sent with parity bit 0 → `frame_err`.
